// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// A radix-2 shift-add multiply or a restoring divide runs for XLEN cycles. Divide-by-zero
// and signed overflow are resolved when the operands are captured, and those take a
// one-clock path. The result is held in a register, and `done` is a one-cycle pulse.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result,
  output logic            zero
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_hi;        // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;        // multiplier / dividend-quotient / special-case value
  logic [XLEN-1:0]   r_b;         // multiplicand / divisor magnitude
  logic [CW-1:0]     r_cnt;
  logic              r_neg_res;   // negate product or quotient
  logic              r_neg_rem;   // negate remainder (dividend was negative)
  logic              r_special;   // result already sits in r_lo

  // Capture-time decode of signedness, magnitudes and special cases
  logic              w_accept;
  logic              w_is_div;
  logic              w_a_signed, w_b_signed;
  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_overflow, w_special;
  logic [XLEN-1:0]   w_special_val;

  assign w_accept   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_is_div   = op[2];
  assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_a_neg    = w_a_signed && SrcA[XLEN-1];
  assign w_b_neg    = w_b_signed && SrcB[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~SrcA + 1'b1) : SrcA;
  assign w_b_mag    = w_b_neg ? (~SrcB + 1'b1) : SrcB;
  assign w_div_zero = w_is_div && (SrcB == '0);
  assign w_overflow = ((op == OP_DIV) || (op == OP_REM)) && (SrcA == MIN_NEG) && (SrcB == '1);
  assign w_special  = w_div_zero || w_overflow;
  // op[1] selects remainder among the divide ops
  assign w_special_val = w_div_zero ? (op[1] ? SrcA : '1)
                                    : (op[1] ? '0   : SrcA);

  // One iteration of each algorithm
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic              w_q_bit;
  logic [XLEN-1:0]   w_sub;

  assign w_sum   = {1'b0, r_hi} + ({1'b0, r_b} & {(XLEN+1){r_lo[0]}});
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_q_bit = (w_shift >= {1'b0, r_b});
  // The trial difference is below the divisor whenever it is kept, so XLEN bits suffice
  assign w_sub   = w_shift[XLEN-1:0] - r_b;

  // Sign correction and result selection used in FIN
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot, w_rem;
  logic [XLEN-1:0]   w_fin;

  assign w_prod_fix = r_neg_res ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
  assign w_quot     = r_neg_res ? (~r_lo + 1'b1) : r_lo;
  assign w_rem      = r_neg_rem ? (~r_hi + 1'b1) : r_hi;

  // Final result mux
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    w_fin = '0;
    if (r_special) begin
      w_fin = r_lo;
    end else begin
      unique case (r_op)
        OP_MUL:                       w_fin = w_prod_fix[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_fin = w_prod_fix[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              w_fin = w_quot;
        OP_REM, OP_REMU:              w_fin = w_rem;
        default:                      w_fin = '0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next_state = w_special ? S_FIN : S_CALC;
        else          w_next_state = S_IDLE;
      end
      S_CALC:  w_next_state = (r_cnt == '0) ? S_FIN : S_CALC;
      S_FIN:   w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (r_state == S_CALC) || (r_state == S_FIN);
    done = (r_state == S_DONE);
  end

  // Operand capture and per-cycle iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_special <= 1'b0;
    end else if (w_accept) begin
      r_op      <= op;
      r_special <= w_special;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_cnt     <= CW'(XLEN - 1);
      r_hi      <= '0;
      if (w_special) begin
        r_lo <= w_special_val;
        r_b  <= '0;
      end else if (w_is_div) begin
        r_lo <= w_a_mag;
        r_b  <= w_b_mag;
      end else begin
        r_lo <= w_b_mag;
        r_b  <= w_a_mag;
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_op[2]) begin
        r_hi <= w_q_bit ? w_sub : w_shift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_q_bit};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  // Result register, loaded only on the FIN -> DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                Result <= '0;
    else if (r_state == S_FIN) Result <= w_fin;
  end

  assign zero = (Result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN = 32).
module tb_muldiv_unit;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;
  logic            zero;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] prev_res = '0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .busy   (busy),
    .done   (done),
    .Result (Result),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait for done, at most 100 edges; returns edges elapsed and whether done appeared.
  task automatic wait_done(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1'b1;
    end
  endtask

  // Issue one operation, scramble inputs after capture, check timing and result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; SrcA = ~a; SrcB = ~b;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_hold"}, Result, prev_res);
    wait_done(lat, got);
    check({tag, "_done"}, {31'd0, got}, 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, Result, exp);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    check({tag, "_nbusy"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    prev_res = exp;
  endtask

  initial begin
    int lat;
    bit got;
    bit seen;

    rst_n = 1'b0; start = 1'b0; op = '0; SrcA = '0; SrcB = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res",  Result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply variants
    run_op("mul",      OP_MUL,    32'd10,        32'd50,        32'd500,       33);
    run_op("mulh_m1",  OP_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  33);
    run_op("mulhu_m1", OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  33);
    run_op("mulhsu",   OP_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  33);
    run_op("mulh_min", OP_MULH,   32'h80000000,  32'd2,         32'hFFFFFFFF,  33);
    run_op("mul_min",  OP_MUL,    32'h80000000,  32'd2,         32'h00000000,  33);
    run_op("mulh_neg", OP_MULH,   32'd7,         32'hFFFFFFFD,  32'hFFFFFFFF,  33);

    // Divide variants
    run_op("div_n7",   OP_DIV,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  33);
    run_op("rem_n7",   OP_REM,    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  33);
    run_op("divu_n7",  OP_DIVU,   32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  33);
    run_op("remu_n7",  OP_REMU,   32'hFFFFFFF9,  32'd2,         32'h00000001,  33);
    run_op("div_7m2",  OP_DIV,    32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  33);
    run_op("rem_7m2",  OP_REM,    32'd7,         32'hFFFFFFFE,  32'h00000001,  33);

    // Special cases, one-clock latency
    run_op("divu_z",   OP_DIVU,   32'd123,       32'd0,         32'hFFFFFFFF,  1);
    run_op("remu_z",   OP_REMU,   32'd123,       32'd0,         32'd123,       1);
    run_op("div_z",    OP_DIV,    32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  1);
    run_op("rem_z",    OP_REM,    32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  1);
    run_op("div_ovf",  OP_DIV,    32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1);
    run_op("rem_ovf",  OP_REM,    32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1);

    // Starts at edges 5 and 10 during a MUL are ignored
    @(negedge clk);
    start = 1'b1; op = OP_MUL; SrcA = 32'd10; SrcB = 32'd50;
    @(posedge clk);
    #1;
    start = 1'b0; op = OP_DIVU; SrcA = 32'd3; SrcB = 32'd4;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      start = (lat == 4 || lat == 9);
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("ign_done", {31'd0, got}, 32'd1);
    check("ign_lat",  lat, 33);
    check("ign_res",  Result, 32'd500);

    // Back-to-back start accepted in the DONE cycle
    start = 1'b1; op = OP_MUL; SrcA = 32'd7; SrcB = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_ndone", {31'd0, done}, 32'd0);
    check("b2b_hold", Result, 32'd500);
    wait_done(lat, got);
    check("b2b_done", {31'd0, got}, 32'd1);
    check("b2b_lat",  lat, 33);
    check("b2b_res",  Result, 32'd42);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; op = OP_DIV; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_res",  Result, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("abort_quiet", {31'd0, seen}, 32'd0);
    prev_res = '0;

    // Normal operation resumes after the abort
    run_op("divu_rec", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
